// File: rtl/pipe_skid32.sv
// pipe_skid32: two-entry skid buffer on a 32-bit valid/ready stream.
// Optional FLUSH port/logic enabled by defining PIPE_SKID32_FLUSH_EN.
module pipe_skid32 (
  input  logic        CLK,
  input  logic        RST,
  input  logic [31:0] IN,
  input  logic        IN_V,
  output logic        IN_RDY,
  output logic [31:0] OUT,
  output logic        OUT_V,
  input  logic        OUT_RDY,
  output logic [1:0]  COUNT
`ifdef PIPE_SKID32_FLUSH_EN
  ,
  input  logic        FLUSH
`endif
);

  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_BUSY  = 2'd1,
    S_FULL  = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] main_q, main_d;
  logic [31:0] skid_q, skid_d;
  logic        in_xfer;
  logic        out_xfer;
  logic        flush_w;

`ifdef PIPE_SKID32_FLUSH_EN
  assign flush_w = FLUSH;
`else
  assign flush_w = 1'b0;
`endif

  assign in_xfer  = IN_V & IN_RDY;
  assign out_xfer = OUT_V & OUT_RDY;

  // Occupancy state register; reset wins over everything.
  always_ff @(posedge CLK) begin
    if (RST) state_q <= S_EMPTY;
    else     state_q <= state_d;
  end

  // Entry storage; cleared on reset, kept across flush.
  always_ff @(posedge CLK) begin
    if (RST) begin
      main_q <= 32'h0;
      skid_q <= 32'h0;
    end else begin
      main_q <= main_d;
      skid_q <= skid_d;
    end
  end

  // Next occupancy from the transfers seen this cycle.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_EMPTY: if (in_xfer) state_d = S_BUSY;
      S_BUSY: begin
        if (in_xfer && !out_xfer)      state_d = S_FULL;
        else if (!in_xfer && out_xfer) state_d = S_EMPTY;
      end
      S_FULL: if (out_xfer) state_d = S_BUSY;
      default: state_d = S_EMPTY;
    endcase
    if (flush_w) state_d = S_EMPTY;
  end

  // Entry writes; a flush drops the same-cycle input.
  always_comb begin
    main_d = main_q;
    skid_d = skid_q;
    if (!flush_w) begin
      unique case (state_q)
        S_EMPTY: if (in_xfer) main_d = IN;
        S_BUSY: begin
          if (in_xfer && out_xfer) main_d = IN;
          else if (in_xfer)        skid_d = IN;
        end
        S_FULL: if (out_xfer) main_d = skid_q;
        default: ;
      endcase
    end
  end

  // Handshake and status outputs, all from registered state.
  always_comb begin
    IN_RDY = (state_q != S_FULL) && !RST;
    OUT_V  = (state_q != S_EMPTY);
    OUT    = main_q;
    COUNT  = state_q;
  end

endmodule

// File: tb/tb_pipe_skid32.sv
// tb_pipe_skid32: scoreboard bench for pipe_skid32.
// Reference is a depth-2 FIFO held in a queue.
module tb_pipe_skid32;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic [31:0] IN = 32'h0;
  logic        IN_V = 1'b0;
  logic        IN_RDY;
  logic [31:0] OUT;
  logic        OUT_V;
  logic        OUT_RDY = 1'b0;
  logic [1:0]  COUNT;
`ifdef PIPE_SKID32_FLUSH_EN
  logic        FLUSH = 1'b0;
`endif

  always #5 CLK = ~CLK;

  pipe_skid32 dut (
    .CLK     (CLK),
    .RST     (RST),
    .IN      (IN),
    .IN_V    (IN_V),
    .IN_RDY  (IN_RDY),
    .OUT     (OUT),
    .OUT_V   (OUT_V),
    .OUT_RDY (OUT_RDY),
    .COUNT   (COUNT)
`ifdef PIPE_SKID32_FLUSH_EN
    ,
    .FLUSH   (FLUSH)
`endif
  );

  int checks = 0;
  int failures = 0;

  logic [31:0] exp_q[$];
  int m_cnt = 0;
  bit m_rdy = 1'b0;
  bit m_rst = 1'b0;
  bit m_rst_prev = 1'b0;
  bit m_clear = 1'b0;
  bit m_go = 1'b0;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Drive one cycle of stimulus and record what the reference expects.
  task automatic cyc(bit rst, bit iv, logic [31:0] d, bit ordy, bit fl);
    bit fl_eff;
    @(negedge CLK);
    #1;
    RST = rst;
    IN_V = iv;
    IN = d;
    OUT_RDY = ordy;
`ifdef PIPE_SKID32_FLUSH_EN
    FLUSH = fl;
    fl_eff = fl;
`else
    fl_eff = fl & 1'b0;
`endif
    #2;
    m_rst_prev = m_rst;
    m_rst = rst;
    m_cnt = exp_q.size();
    m_rdy = !rst && (m_cnt < 2);
    m_clear = rst || fl_eff;
    if (m_rdy && iv && !m_clear) exp_q.push_back(d);
    m_go = 1'b1;
  endtask

  // Monitor: just before each rising edge, compare DUT to the reference.
  initial begin
    forever begin
      @(negedge CLK);
      #4;
      if (m_go) begin
        m_go = 1'b0;
        chk("in_rdy", {31'h0, IN_RDY}, {31'h0, m_rdy});
        if (m_rst) begin
          if (m_rst_prev) begin
            chk("rst_count", {30'h0, COUNT}, 32'd0);
            chk("rst_out_v", {31'h0, OUT_V}, 32'd0);
            chk("rst_out", OUT, 32'h0);
          end
        end else begin
          chk("count", {30'h0, COUNT}, m_cnt);
          chk("out_v", {31'h0, OUT_V}, {31'h0, (m_cnt != 0)});
          if (m_cnt > 0) chk("out", OUT, exp_q[0]);
        end
        if (m_clear) exp_q.delete();
        else if (m_cnt > 0 && OUT_RDY) void'(exp_q.pop_front());
      end
    end
  end

  initial begin
    bit fl;
    // Reset with a word offered
    cyc(1, 1, 32'hAAAAAAAA, 0, 0);
    cyc(1, 1, 32'hAAAAAAAA, 0, 0);
    // Pass-through
    cyc(0, 1, 32'h55555555, 1, 0);
    cyc(0, 1, 32'hAAAAAAAA, 1, 0);
    cyc(0, 0, 32'h0, 1, 0);
    cyc(0, 0, 32'h0, 1, 0);
    // Backpressure, third word refused
    cyc(0, 1, 32'h11111111, 0, 0);
    cyc(0, 1, 32'h22222222, 0, 0);
    cyc(0, 1, 32'h33333333, 0, 0);
    cyc(0, 1, 32'h33333333, 0, 0);
    cyc(0, 0, 32'h0, 1, 0);
    cyc(0, 0, 32'h0, 1, 0);
    cyc(0, 0, 32'h0, 1, 0);
    // Simultaneous in/out while busy
    cyc(0, 1, 32'hDEADBEEF, 0, 0);
    cyc(0, 1, 32'hCAFEF00D, 1, 0);
    cyc(0, 0, 32'h0, 0, 0);
    cyc(0, 0, 32'h0, 1, 0);
    cyc(0, 0, 32'h0, 1, 0);
`ifdef PIPE_SKID32_FLUSH_EN
    // Flush from full with a word offered
    cyc(0, 1, 32'h01010101, 0, 0);
    cyc(0, 1, 32'h02020202, 0, 0);
    cyc(0, 1, 32'h03030303, 0, 1);
    cyc(0, 0, 32'h0, 0, 0);
    cyc(0, 1, 32'h04040404, 1, 0);
    cyc(0, 0, 32'h0, 1, 0);
`endif
    // Random traffic with a mid-run reset
    for (int i = 0; i < 1000; i++) begin
      fl = 1'b0;
`ifdef PIPE_SKID32_FLUSH_EN
      fl = ($urandom_range(0, 49) == 0);
`endif
      if (i == 500 || i == 501)
        cyc(1, 1, $urandom, $urandom_range(0, 1) == 1, 0);
      else
        cyc(0, $urandom_range(0, 3) != 0, $urandom,
            $urandom_range(0, 2) != 0, fl);
    end
    cyc(0, 0, 32'h0, 1, 0);
    cyc(0, 0, 32'h0, 1, 0);
    @(negedge CLK);
    #6;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
